// File: rtl/decode_stage_hz.sv
// Decode stage: instruction decode, register file with write-back bypass,
// load-use hazard detection and the D->E pipeline register.
module decode_stage_hz #(
  parameter int XLEN      = 32,
  parameter bit BYPASS_EN = 1'b1,
  parameter bit HAZARD_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     InstrD,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] PCPlus4D,
  input  logic            ValidD,
  input  logic            RegWriteW,
  input  logic [4:0]      RDW,
  input  logic [XLEN-1:0] ResultW,
  input  logic            HoldE,
  input  logic            FlushE,
  output logic            StallD,
  output logic            RegWriteE,
  output logic            ALUSrcE,
  output logic            MemWriteE,
  output logic            ResultSrcE,
  output logic            BranchE,
  output logic            ValidE,
  output logic [2:0]      ALUControlE,
  output logic [XLEN-1:0] RD1_E,
  output logic [XLEN-1:0] RD2_E,
  output logic [XLEN-1:0] Imm_Ext_E,
  output logic [XLEN-1:0] PCE,
  output logic [XLEN-1:0] PCPlus4E,
  output logic [4:0]      RS1_E,
  output logic [4:0]      RS2_E,
  output logic [4:0]      RD_E
);

  typedef struct packed {
    logic            reg_write;
    logic            alu_src;
    logic            mem_write;
    logic            result_src;
    logic            branch;
    logic            valid;
    logic [2:0]      alu_ctl;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
  } e_t;

  e_t              r_e, w_dec;
  logic [XLEN-1:0] r_rf [32];

  logic [6:0]      w_op;
  logic [2:0]      w_f3;
  logic [4:0]      w_rs1, w_rs2, w_rd;
  logic            w_is_r, w_is_i, w_is_l, w_is_s, w_is_b, w_legal, w_use2;
  logic [2:0]      w_alu;
  logic [XLEN-1:0] w_imm, w_rd1, w_rd2;
  logic            w_wb, w_lu;

  assign w_op  = InstrD[6:0];
  assign w_f3  = InstrD[14:12];
  assign w_rd  = InstrD[11:7];
  assign w_rs1 = InstrD[19:15];
  assign w_rs2 = InstrD[24:20];

  assign w_is_r  = (w_op == 7'b0110011);
  assign w_is_i  = (w_op == 7'b0010011);
  assign w_is_l  = (w_op == 7'b0000011);
  assign w_is_s  = (w_op == 7'b0100011);
  assign w_is_b  = (w_op == 7'b1100011);
  assign w_legal = w_is_r | w_is_i | w_is_l | w_is_s | w_is_b;
  assign w_use2  = w_is_r | w_is_s | w_is_b;

  always_comb begin
    w_alu = 3'b000;
    case (w_f3)
      3'b000:  w_alu = (w_is_r && InstrD[30]) ? 3'b001 : 3'b000;
      3'b111:  w_alu = 3'b010;
      3'b110:  w_alu = 3'b011;
      3'b010:  w_alu = 3'b101;
      default: w_alu = 3'b000;
    endcase
    if (w_is_l || w_is_s) w_alu = 3'b000;
    if (w_is_b)           w_alu = 3'b001;
  end

  always_comb begin
    w_imm = '0;
    if (w_is_i || w_is_l)
      w_imm = {{(XLEN-12){InstrD[31]}}, InstrD[31:20]};
    else if (w_is_s)
      w_imm = {{(XLEN-12){InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
    else if (w_is_b)
      w_imm = {{(XLEN-13){InstrD[31]}}, InstrD[31], InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
  end

  // x0 is never written, so a plain array read already yields 0 for it.
  assign w_wb  = RegWriteW && (RDW != 5'd0);
  assign w_rd1 = (BYPASS_EN && w_wb && RDW == w_rs1) ? ResultW : r_rf[w_rs1];
  assign w_rd2 = (BYPASS_EN && w_wb && RDW == w_rs2) ? ResultW : r_rf[w_rs2];

  // Index/data fields the instruction does not use are zeroed so E only
  // carries meaningful operands.
  always_comb begin
    w_dec = '0;
    if (ValidD && w_legal) begin
      w_dec.reg_write  = w_is_r | w_is_i | w_is_l;
      w_dec.alu_src    = w_is_i | w_is_l | w_is_s;
      w_dec.mem_write  = w_is_s;
      w_dec.result_src = w_is_l;
      w_dec.branch     = w_is_b;
      w_dec.valid      = 1'b1;
      w_dec.alu_ctl    = w_alu;
      w_dec.rd1        = w_rd1;
      w_dec.rd2        = w_use2 ? w_rd2 : '0;
      w_dec.imm        = w_imm;
      w_dec.pc         = PCD;
      w_dec.pc4        = PCPlus4D;
      w_dec.rs1        = w_rs1;
      w_dec.rs2        = w_use2 ? w_rs2 : 5'd0;
      w_dec.rd         = w_dec.reg_write ? w_rd : 5'd0;
    end
  end

  assign w_lu = HAZARD_EN && r_e.valid && r_e.result_src && r_e.reg_write &&
                (r_e.rd != 5'd0) && ValidD && w_legal &&
                ((w_rs1 == r_e.rd) || (w_use2 && w_rs2 == r_e.rd));

  assign StallD = rst && (HoldE || (!FlushE && w_lu));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_e <= '0;
    else if (!HoldE)
      r_e <= (FlushE || w_lu) ? '0 : w_dec;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) r_rf[i] <= '0;
    end else if (w_wb) begin
      r_rf[RDW] <= ResultW;
    end
  end

  assign RegWriteE   = r_e.reg_write;
  assign ALUSrcE     = r_e.alu_src;
  assign MemWriteE   = r_e.mem_write;
  assign ResultSrcE  = r_e.result_src;
  assign BranchE     = r_e.branch;
  assign ValidE      = r_e.valid;
  assign ALUControlE = r_e.alu_ctl;
  assign RD1_E       = r_e.rd1;
  assign RD2_E       = r_e.rd2;
  assign Imm_Ext_E   = r_e.imm;
  assign PCE         = r_e.pc;
  assign PCPlus4E    = r_e.pc4;
  assign RS1_E       = r_e.rs1;
  assign RS2_E       = r_e.rs2;
  assign RD_E        = r_e.rd;

endmodule
